// File: rtl/jellyvl_divider_pkg.sv
// Shared types and helpers for the multicycle restoring divider.
// Holds the FSM state encoding and the iteration-count calculation.
package jellyvl_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_cycles(input int width, input int bits_per_cycle);
    return (width + bits_per_cycle - 1) / bits_per_cycle;
  endfunction

endpackage

// File: rtl/jellyvl_divider_step.sv
// One combinational restoring radix-2 step: shift in a dividend bit and
// subtract the divisor when it fits.
module jellyvl_divider_step #(
  parameter int DIVISOR_WIDTH = 32
) (
  input  logic [DIVISOR_WIDTH-1:0] rem_in,
  input  logic                     dividend_bit,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH-1:0] rem_out,
  output logic                     quotient_bit
);

  logic [DIVISOR_WIDTH:0] shifted;
  logic [DIVISOR_WIDTH:0] diff;

  // With rem_in < divisor the shifted value is below 2*divisor, so the top
  // bit of the difference is a clean borrow flag.
  assign shifted      = {rem_in, dividend_bit};
  assign diff         = shifted - {1'b0, divisor};
  assign quotient_bit = ~diff[DIVISOR_WIDTH];
  assign rem_out      = quotient_bit ? diff[DIVISOR_WIDTH-1:0] : shifted[DIVISOR_WIDTH-1:0];

endmodule

// File: rtl/jellyvl_divider_multicycle.sv
// Multicycle restoring divider with valid/ready handshakes, optional signed
// operands and BITS_PER_CYCLE quotient bits resolved per clock-enabled edge.
module jellyvl_divider_multicycle
  import jellyvl_divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH  = 32,
  parameter int DIVISOR_WIDTH   = 32,
  parameter int QUOTIENT_WIDTH  = DIVIDEND_WIDTH,
  parameter int REMAINDER_WIDTH = DIVISOR_WIDTH,
  parameter int BITS_PER_CYCLE  = 1,
  parameter int SIGNED          = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cke,
  input  logic [DIVIDEND_WIDTH-1:0]  s_dividend,
  input  logic [DIVISOR_WIDTH-1:0]   s_divisor,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [QUOTIENT_WIDTH-1:0]  m_quotient,
  output logic [REMAINDER_WIDTH-1:0] m_remainder,
  output logic                       m_div_by_zero,
  output logic                       m_valid,
  input  logic                       m_ready
);

  localparam int CYCLES    = calc_cycles(DIVIDEND_WIDTH, BITS_PER_CYCLE);
  localparam int PAD_WIDTH = CYCLES * BITS_PER_CYCLE;
  localparam int CNT_WIDTH = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam int QX_WIDTH  = (PAD_WIDTH > QUOTIENT_WIDTH) ? PAD_WIDTH : QUOTIENT_WIDTH;
  localparam int RX_WIDTH  = (DIVISOR_WIDTH > REMAINDER_WIDTH) ? DIVISOR_WIDTH : REMAINDER_WIDTH;
  localparam int EXT_WIDTH = (DIVIDEND_WIDTH > REMAINDER_WIDTH) ? DIVIDEND_WIDTH : REMAINDER_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(CYCLES - 1);

  state_t state;
  state_t state_next;
  logic   accept;

  logic [CNT_WIDTH-1:0]       count;
  logic [PAD_WIDTH-1:0]       work;
  logic [DIVISOR_WIDTH-1:0]   rem;
  logic [DIVISOR_WIDTH-1:0]   divisor_mag;
  logic                       quo_neg;
  logic                       rem_neg;
  logic                       zero_div;
  logic [REMAINDER_WIDTH-1:0] zero_rem;

  logic                      dividend_neg;
  logic                      divisor_neg;
  logic [DIVIDEND_WIDTH-1:0] dividend_mag_in;
  logic [DIVISOR_WIDTH-1:0]  divisor_mag_in;
  logic [EXT_WIDTH-1:0]      dividend_ext;

  assign dividend_neg    = (SIGNED != 0) && s_dividend[DIVIDEND_WIDTH-1];
  assign divisor_neg     = (SIGNED != 0) && s_divisor[DIVISOR_WIDTH-1];
  assign dividend_mag_in = dividend_neg ? -s_dividend : s_dividend;
  assign divisor_mag_in  = divisor_neg ? -s_divisor : s_divisor;

  always_comb begin
    if (SIGNED != 0) dividend_ext = EXT_WIDTH'($signed(s_dividend));
    else             dividend_ext = EXT_WIDTH'(s_dividend);
  end

  // The work register shifts dividend bits out of the top and quotient bits
  // in at the bottom, so it holds the full quotient magnitude when done.
  logic [DIVISOR_WIDTH-1:0]  rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] quo_bits;
  logic [PAD_WIDTH-1:0]      work_next;

  assign rem_chain[0] = rem;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    jellyvl_divider_step #(
      .DIVISOR_WIDTH (DIVISOR_WIDTH)
    ) u_step (
      .rem_in       (rem_chain[i]),
      .dividend_bit (work[PAD_WIDTH-1-i]),
      .divisor      (divisor_mag),
      .rem_out      (rem_chain[i+1]),
      .quotient_bit (quo_bits[BITS_PER_CYCLE-1-i])
    );
  end

  assign work_next = (work << BITS_PER_CYCLE) | PAD_WIDTH'(quo_bits);

  logic [QX_WIDTH-1:0] quo_mag;
  logic [QX_WIDTH-1:0] quo_fix;
  logic [RX_WIDTH-1:0] rem_mag;
  logic [RX_WIDTH-1:0] rem_fix;

  assign quo_mag = QX_WIDTH'(work_next);
  assign quo_fix = quo_neg ? -quo_mag : quo_mag;
  assign rem_mag = RX_WIDTH'(rem_chain[BITS_PER_CYCLE]);
  assign rem_fix = rem_neg ? -rem_mag : rem_mag;

  assign accept = s_valid && s_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= IDLE;
    else if (cke) state <= state_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (count == '0) state_next = DONE;
      DONE: begin
        if (accept)       state_next = CALC;
        else if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    case (state)
      IDLE:    s_ready = 1'b1;
      DONE:    s_ready = m_ready;
      default: s_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      work          <= '0;
      rem           <= '0;
      divisor_mag   <= '0;
      quo_neg       <= 1'b0;
      rem_neg       <= 1'b0;
      zero_div      <= 1'b0;
      zero_rem      <= '0;
      m_quotient    <= '0;
      m_remainder   <= '0;
      m_div_by_zero <= 1'b0;
      m_valid       <= 1'b0;
    end else if (cke) begin
      if (accept) begin
        work        <= PAD_WIDTH'(dividend_mag_in);
        rem         <= '0;
        divisor_mag <= divisor_mag_in;
        quo_neg     <= dividend_neg ^ divisor_neg;
        rem_neg     <= dividend_neg;
        zero_div    <= (s_divisor == '0);
        zero_rem    <= dividend_ext[REMAINDER_WIDTH-1:0];
        count       <= LAST_COUNT;
      end else if (state == CALC) begin
        work  <= work_next;
        rem   <= rem_chain[BITS_PER_CYCLE];
        count <= count - 1'b1;
      end

      // Sign fix-up rides on the final iteration edge, so it costs no latency.
      if (state == CALC && count == '0) begin
        m_valid       <= 1'b1;
        m_div_by_zero <= zero_div;
        m_quotient    <= zero_div ? '1 : quo_fix[QUOTIENT_WIDTH-1:0];
        m_remainder   <= zero_div ? zero_rem : rem_fix[REMAINDER_WIDTH-1:0];
      end else if (state == DONE && m_ready) begin
        m_valid       <= 1'b0;
        m_div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jellyvl_divider_multicycle.sv
// Directed bench for three divider configurations: unsigned radix-2,
// unsigned 4 bits per cycle, and signed 8-bit with 3 bits per cycle.
module tb_jellyvl_divider_multicycle;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  logic clk;
  logic rst;
  logic cke;
  bit   rnd_cke;

  logic [31:0] dvd [3];
  logic [31:0] dvs [3];
  logic        sv  [3];
  logic        mr  [3];
  logic [31:0] q   [3];
  logic [31:0] r   [3];
  logic        dz  [3];
  logic        mv  [3];
  logic        sr  [3];

  logic [7:0] s8_q;
  logic [7:0] s8_r;

  int n_checks = 0;
  int n_fail   = 0;

  jellyvl_divider_multicycle #(
    .DIVIDEND_WIDTH (32), .DIVISOR_WIDTH (32), .BITS_PER_CYCLE (1), .SIGNED (0)
  ) u_u32 (
    .clk (clk), .rst (rst), .cke (cke),
    .s_dividend (dvd[0]), .s_divisor (dvs[0]), .s_valid (sv[0]), .s_ready (sr[0]),
    .m_quotient (q[0]), .m_remainder (r[0]), .m_div_by_zero (dz[0]),
    .m_valid (mv[0]), .m_ready (mr[0])
  );

  jellyvl_divider_multicycle #(
    .DIVIDEND_WIDTH (32), .DIVISOR_WIDTH (32), .BITS_PER_CYCLE (4), .SIGNED (0)
  ) u_b4 (
    .clk (clk), .rst (rst), .cke (cke),
    .s_dividend (dvd[1]), .s_divisor (dvs[1]), .s_valid (sv[1]), .s_ready (sr[1]),
    .m_quotient (q[1]), .m_remainder (r[1]), .m_div_by_zero (dz[1]),
    .m_valid (mv[1]), .m_ready (mr[1])
  );

  jellyvl_divider_multicycle #(
    .DIVIDEND_WIDTH (8), .DIVISOR_WIDTH (8), .BITS_PER_CYCLE (3), .SIGNED (1)
  ) u_s8 (
    .clk (clk), .rst (rst), .cke (cke),
    .s_dividend (dvd[2][7:0]), .s_divisor (dvs[2][7:0]), .s_valid (sv[2]), .s_ready (sr[2]),
    .m_quotient (s8_q), .m_remainder (s8_r), .m_div_by_zero (dz[2]),
    .m_valid (mv[2]), .m_ready (mr[2])
  );

  assign q[2] = {24'h0, s8_q};
  assign r[2] = {24'h0, s8_r};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Clock enable changes shortly after each rising edge, so it is stable at
  // both the falling edge (stimulus) and the next rising edge.
  initial begin
    cke = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cke = rnd_cke ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_op(input int k, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    dvd[k] = a;
    dvs[k] = b;
    sv[k]  = 1'b1;
    while (!(cke && sr[k]) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout inst %0d: s_ready=%b required 1", k, sr[k]);
    end
    @(posedge clk);
    #1;
    sv[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int lat, output bit tmo);
    int edges = 0;
    lat = 0;
    while (!mv[k] && edges < 2000) begin
      @(posedge clk);
      if (cke) lat++;
      edges++;
      #1;
    end
    tmo = !mv[k];
  endtask

  task automatic release_op(input int k);
    @(negedge clk);
    mr[k] = 1'b1;
    while (!cke) @(negedge clk);
    @(posedge clk);
    #1;
    mr[k] = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (mv[k] !== 1'b0 || sr[k] !== 1'b1 || dz[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_flags inst %0d: valid=%b ready=%b dz=%b required 0 1 0", k, mv[k], sr[k], dz[k]);
      end
      n_checks++;
      if (q[k] !== 32'h0 || r[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_data inst %0d: q=%h r=%h required 0 0", k, q[k], r[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    vec_t v [4];
    int   lat;
    bit   tmo;
    v[0] = '{32'd100,        32'd7,  32'd14,         32'd2, 1'b0};
    v[1] = '{32'hFFFF_FFFF,  32'd1,  32'hFFFF_FFFF,  32'd0, 1'b0};
    v[2] = '{32'd5,          32'd10, 32'd0,          32'd5, 1'b0};
    v[3] = '{32'h8000_0000,  32'd3,  32'h2AAA_AAAA,  32'd2, 1'b0};
    foreach (v[i]) begin
      start_op(0, v[i].a, v[i].b);
      wait_valid(0, lat, tmo);
      n_checks++;
      if (tmo || lat != 32) begin
        n_fail++;
        $display("FAIL u32_latency vec %0d: got %0d edges (timeout=%b) required 32", i, lat, tmo);
      end
      n_checks++;
      if (q[0] !== v[i].q || r[0] !== v[i].r || dz[0] !== v[i].dz) begin
        n_fail++;
        $display("FAIL u32_result vec %0d: q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                 i, q[0], r[0], dz[0], v[i].q, v[i].r, v[i].dz);
      end
      release_op(0);
      n_checks++;
      if (mv[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL u32_release vec %0d: m_valid=%b required 0", i, mv[0]);
      end
    end
  endtask

  task automatic test_radix4();
    vec_t v [3];
    int   lat;
    bit   tmo;
    v[0] = '{32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF,  1'b0};
    v[1] = '{32'd1000,      32'd33, 32'd30,        32'd10, 1'b0};
    v[2] = '{32'd0,         32'd5,  32'd0,         32'd0,  1'b0};
    foreach (v[i]) begin
      start_op(1, v[i].a, v[i].b);
      wait_valid(1, lat, tmo);
      n_checks++;
      if (tmo || lat != 8) begin
        n_fail++;
        $display("FAIL b4_latency vec %0d: got %0d edges (timeout=%b) required 8", i, lat, tmo);
      end
      n_checks++;
      if (q[1] !== v[i].q || r[1] !== v[i].r || dz[1] !== v[i].dz) begin
        n_fail++;
        $display("FAIL b4_result vec %0d: q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                 i, q[1], r[1], dz[1], v[i].q, v[i].r, v[i].dz);
      end
      release_op(1);
    end
  endtask

  task automatic test_signed();
    vec_t v [5];
    int   lat;
    bit   tmo;
    v[0] = '{32'hF9, 32'h02, 32'hFD, 32'hFF, 1'b0};  // -7 / 2
    v[1] = '{32'h07, 32'hFE, 32'hFD, 32'h01, 1'b0};  // 7 / -2
    v[2] = '{32'h80, 32'hFF, 32'h80, 32'h00, 1'b0};  // -128 / -1
    v[3] = '{32'h80, 32'h03, 32'hD6, 32'hFE, 1'b0};  // -128 / 3
    v[4] = '{32'h64, 32'hF9, 32'hF2, 32'h02, 1'b0};  // 100 / -7
    foreach (v[i]) begin
      start_op(2, v[i].a, v[i].b);
      wait_valid(2, lat, tmo);
      n_checks++;
      if (tmo || lat != 3) begin
        n_fail++;
        $display("FAIL s8_latency vec %0d: got %0d edges (timeout=%b) required 3", i, lat, tmo);
      end
      n_checks++;
      if (q[2] !== v[i].q || r[2] !== v[i].r || dz[2] !== v[i].dz) begin
        n_fail++;
        $display("FAIL s8_result vec %0d: q=%h r=%h dz=%b required q=%h r=%h dz=%b",
                 i, q[2], r[2], dz[2], v[i].q, v[i].r, v[i].dz);
      end
      release_op(2);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    bit tmo;
    start_op(0, 32'd5, 32'd0);
    wait_valid(0, lat, tmo);
    n_checks++;
    if (tmo || lat != 32) begin
      n_fail++;
      $display("FAIL u32_dz_latency: got %0d edges (timeout=%b) required 32", lat, tmo);
    end
    n_checks++;
    if (q[0] !== 32'hFFFF_FFFF || r[0] !== 32'd5 || dz[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL u32_dz_result: q=%h r=%h dz=%b required q=ffffffff r=00000005 dz=1", q[0], r[0], dz[0]);
    end
    release_op(0);
    n_checks++;
    if (dz[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL u32_dz_clear: dz=%b required 0", dz[0]);
    end

    start_op(2, 32'hFD, 32'h00);
    wait_valid(2, lat, tmo);
    n_checks++;
    if (tmo || lat != 3) begin
      n_fail++;
      $display("FAIL s8_dz_latency: got %0d edges (timeout=%b) required 3", lat, tmo);
    end
    n_checks++;
    if (q[2] !== 32'hFF || r[2] !== 32'hFD || dz[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL s8_dz_result: q=%h r=%h dz=%b required q=ff r=fd dz=1", q[2], r[2], dz[2]);
    end
    release_op(2);
  endtask

  task automatic test_back_to_back();
    int lat;
    bit tmo;
    start_op(1, 32'd1000, 32'd33);
    wait_valid(1, lat, tmo);
    n_checks++;
    if (tmo || q[1] !== 32'd30 || r[1] !== 32'd10) begin
      n_fail++;
      $display("FAIL b2b_first: q=%h r=%h timeout=%b required q=1e r=0a", q[1], r[1], tmo);
    end
    @(negedge clk);
    dvd[1] = 32'd77;
    dvs[1] = 32'd7;
    sv[1]  = 1'b1;
    mr[1]  = 1'b0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (mv[1] !== 1'b1 || q[1] !== 32'd30 || r[1] !== 32'd10 || sr[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold edge %0d: valid=%b q=%h r=%h ready=%b required 1 1e 0a 0",
                 e, mv[1], q[1], r[1], sr[1]);
      end
    end
    @(negedge clk);
    mr[1] = 1'b1;
    #1;
    n_checks++;
    if (sr[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: s_ready=%b required 1", sr[1]);
    end
    @(posedge clk);
    #1;
    sv[1] = 1'b0;
    mr[1] = 1'b0;
    n_checks++;
    if (mv[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drop_valid: m_valid=%b required 0", mv[1]);
    end
    wait_valid(1, lat, tmo);
    n_checks++;
    if (tmo || lat != 8) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d edges (timeout=%b) required 8", lat, tmo);
    end
    n_checks++;
    if (q[1] !== 32'd11 || r[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_second: q=%h r=%h required q=0b r=0", q[1], r[1]);
    end
    release_op(1);
  endtask

  task automatic test_cke_random();
    int lat;
    bit tmo;
    rnd_cke = 1'b1;
    start_op(1, 32'hFFFF_FFFF, 32'h10);
    wait_valid(1, lat, tmo);
    n_checks++;
    if (tmo || lat != 8) begin
      n_fail++;
      $display("FAIL cke_latency: got %0d enabled edges (timeout=%b) required 8", lat, tmo);
    end
    n_checks++;
    if (q[1] !== 32'h0FFF_FFFF || r[1] !== 32'hF) begin
      n_fail++;
      $display("FAIL cke_result: q=%h r=%h required q=0fffffff r=0000000f", q[1], r[1]);
    end
    rnd_cke = 1'b0;
    release_op(1);
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bit tmo;
    bit stale = 1'b0;
    start_op(0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (mv[0] !== 1'b0 || sr[0] !== 1'b1 || q[0] !== 32'h0 || r[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b ready=%b q=%h r=%h required 0 1 0 0", mv[0], sr[0], q[0], r[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mv[0]) stale = 1'b1;
    end
    n_checks++;
    if (stale) begin
      n_fail++;
      $display("FAIL stale_result: m_valid rose after reset release, required none");
    end
    start_op(0, 32'd100, 32'd7);
    wait_valid(0, lat, tmo);
    n_checks++;
    if (tmo || lat != 32 || q[0] !== 32'd14 || r[0] !== 32'd2) begin
      n_fail++;
      $display("FAIL post_reset_op: lat=%0d q=%h r=%h timeout=%b required 32 0e 02", lat, q[0], r[0], tmo);
    end
    release_op(0);
  endtask

  initial begin
    rst     = 1'b1;
    rnd_cke = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dvd[k] = '0;
      dvs[k] = '0;
      sv[k]  = 1'b0;
      mr[k]  = 1'b0;
    end
    test_reset();
    test_unsigned();
    test_radix4();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_cke_random();
    test_reset_mid_calc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
